// File: rtl/ecc_pkg.sv
// Shared definitions for the ECC read stage: default widths and the
// error-capture state type.
package ecc_pkg;

  localparam int unsigned ECC_DATA_W   = 56;
  localparam int unsigned ECC_PAR_W    = 7;
  localparam int unsigned ECC_ADDR_W   = 8;
  localparam int unsigned ECC_CNT_W    = 16;
  localparam int unsigned ECC_SBIT_THR = 16;

  typedef enum logic [1:0] {
    CAP_IDLE    = 2'd0,
    CAP_SB_HELD = 2'd1,
    CAP_DB_HELD = 2'd2
  } cap_state_e;

endpackage

// File: rtl/ecc_skid_buf.sv
// Two-entry FIFO with a registered ready; gives 1-cycle latency and
// full throughput when the consumer keeps pace.
module ecc_skid_buf
  import ecc_pkg::*;
#(
  parameter int unsigned PAYLOAD_W = ECC_DATA_W + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload
);

  logic [PAYLOAD_W-1:0] slot0, slot1;
  logic                 wr_ptr, rd_ptr;
  logic [1:0]           count, count_nxt;
  logic                 push, pop;

  assign push        = in_valid && in_ready;
  assign pop         = out_valid && out_ready;
  assign out_valid   = (count != 2'd0);
  assign out_payload = rd_ptr ? slot1 : slot0;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 2'd1;
      2'b01:   count_nxt = count - 2'd1;
      default: count_nxt = count;
    endcase
  end

  // in_ready is held low through reset and rises on the first edge after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0    <= '0;
      slot1    <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= '0;
      in_ready <= 1'b0;
    end else begin
      if (push) begin
        if (wr_ptr) slot1 <= in_payload;
        else        slot0 <= in_payload;
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count    <= count_nxt;
      in_ready <= (count_nxt != 2'd2);
    end
  end

endmodule

// File: rtl/ecc_56_rd_stage.sv
// ECC read-return stage: buffers corrected words downstream, marks
// uncorrectable words as poisoned, and keeps error counters/capture status.
module ecc_56_rd_stage
  import ecc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = ECC_DATA_W,
  parameter int unsigned ADDR_W     = ECC_ADDR_W,
  parameter int unsigned CNT_W      = ECC_CNT_W,
  parameter int unsigned SBIT_THR   = ECC_SBIT_THR
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_sbit_err,
  input  logic                  in_dbit_err,
  input  logic [ADDR_W-1:0]     in_addr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_poison,
  input  logic                  err_clr,
  output logic [CNT_W-1:0]      sbit_cnt,
  output logic [CNT_W-1:0]      dbit_cnt,
  output logic [ADDR_W-1:0]     err_addr,
  output logic                  err_addr_vld,
  output logic                  err_irq
);

  logic [DATA_WIDTH:0] in_payload, out_payload;
  logic                accept, sbit_ev, dbit_ev;
  cap_state_e          state, state_nxt;
  logic [CNT_W-1:0]    sbit_cnt_nxt, dbit_cnt_nxt;
  logic [ADDR_W-1:0]   err_addr_nxt;
  logic                err_irq_nxt;

  assign in_payload = {in_dbit_err, in_data};
  assign out_data   = out_payload[DATA_WIDTH-1:0];
  assign out_poison = out_payload[DATA_WIDTH];

  ecc_skid_buf #(
    .PAYLOAD_W(DATA_WIDTH + 1)
  ) u_skid_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_payload (in_payload),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_payload(out_payload)
  );

  assign accept  = in_valid && in_ready;
  assign dbit_ev = accept && in_dbit_err;
  assign sbit_ev = accept && in_sbit_err && !in_dbit_err;

  assign err_addr_vld = (state != CAP_IDLE);

  // Clear is applied first so a same-cycle beat lands on the cleared state.
  always_comb begin
    sbit_cnt_nxt = err_clr ? '0 : sbit_cnt;
    dbit_cnt_nxt = err_clr ? '0 : dbit_cnt;
    err_addr_nxt = err_clr ? '0 : err_addr;
    state_nxt    = err_clr ? CAP_IDLE : state;
    if (dbit_ev) begin
      if (dbit_cnt_nxt != '1) dbit_cnt_nxt = dbit_cnt_nxt + CNT_W'(1);
      if (state_nxt != CAP_DB_HELD) begin
        state_nxt    = CAP_DB_HELD;
        err_addr_nxt = in_addr;
      end
    end else if (sbit_ev) begin
      if (sbit_cnt_nxt != '1) sbit_cnt_nxt = sbit_cnt_nxt + CNT_W'(1);
      if (state_nxt == CAP_IDLE) begin
        state_nxt    = CAP_SB_HELD;
        err_addr_nxt = in_addr;
      end
    end
    err_irq_nxt = (state_nxt == CAP_DB_HELD) || (32'(sbit_cnt_nxt) >= SBIT_THR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= CAP_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sbit_cnt <= '0;
      dbit_cnt <= '0;
      err_addr <= '0;
      err_irq  <= 1'b0;
    end else begin
      sbit_cnt <= sbit_cnt_nxt;
      dbit_cnt <= dbit_cnt_nxt;
      err_addr <= err_addr_nxt;
      err_irq  <= err_irq_nxt;
    end
  end

endmodule

// File: tb/tb_ecc_56_rd_stage.sv
// Bench for ecc_56_rd_stage: directed scenarios with literal expectations plus
// randomized traffic against a queue-based model, on default and CNT_W=4 instances.
module tb_ecc_56_rd_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, in_sbit_err, in_dbit_err, out_ready, err_clr;
  logic [55:0] in_data;
  logic [7:0]  in_addr;

  logic        in_ready, out_valid, out_poison, err_addr_vld, err_irq;
  logic [55:0] out_data;
  logic [15:0] sbit_cnt, dbit_cnt;
  logic [7:0]  err_addr;

  logic        in_ready4, out_valid4, out_poison4, err_addr_vld4, err_irq4;
  logic [55:0] out_data4;
  logic [3:0]  sbit_cnt4, dbit_cnt4;
  logic [7:0]  err_addr4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ecc_56_rd_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sbit_err(in_sbit_err), .in_dbit_err(in_dbit_err), .in_addr(in_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_poison(out_poison),
    .err_clr(err_clr), .sbit_cnt(sbit_cnt), .dbit_cnt(dbit_cnt),
    .err_addr(err_addr), .err_addr_vld(err_addr_vld), .err_irq(err_irq)
  );

  ecc_56_rd_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
    .in_sbit_err(in_sbit_err), .in_dbit_err(in_dbit_err), .in_addr(in_addr),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4), .out_poison(out_poison4),
    .err_clr(err_clr), .sbit_cnt(sbit_cnt4), .dbit_cnt(dbit_cnt4),
    .err_addr(err_addr4), .err_addr_vld(err_addr_vld4), .err_irq(err_irq4)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned sat(input int unsigned x, input int unsigned m);
    return (x > m) ? m : x;
  endfunction

  // Reference model: a queue of beats in flight, raw error totals since the
  // last clear, and the capture status (0 none, 1 single held, 2 double held).
  typedef struct {
    logic [55:0] d;
    logic        p;
  } beat_t;

  beat_t       mq[$];
  bit          m_ready = 1'b0;
  int unsigned sb_tot = 0, db_tot = 0;
  int          m_st = 0;
  logic [7:0]  m_addr = '0;
  bit          m_acc, m_pop;
  beat_t       m_b;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_ready = 1'b0;
      sb_tot  = 0;
      db_tot  = 0;
      m_st    = 0;
      m_addr  = '0;
    end else begin
      m_acc = in_valid && m_ready;
      m_pop = (mq.size() > 0) && out_ready;
      if (m_pop) void'(mq.pop_front());
      if (m_acc) begin
        m_b.d = in_data;
        m_b.p = in_dbit_err;
        mq.push_back(m_b);
      end
      m_ready = (mq.size() < 2);
      if (err_clr) begin
        sb_tot = 0;
        db_tot = 0;
        m_st   = 0;
        m_addr = '0;
      end
      if (m_acc && in_dbit_err) begin
        db_tot++;
        if (m_st != 2) begin m_st = 2; m_addr = in_addr; end
      end else if (m_acc && in_sbit_err) begin
        sb_tot++;
        if (m_st == 0) begin m_st = 1; m_addr = in_addr; end
      end
    end
  end

  always @(negedge clk) begin
    chk("out_valid", out_valid, mq.size() > 0);
    chk("out_valid4", out_valid4, mq.size() > 0);
    if (mq.size() > 0) begin
      chk("out_data", out_data, mq[0].d);
      chk("out_poison", out_poison, mq[0].p);
      chk("out_data4", out_data4, mq[0].d);
    end
    chk("in_ready", in_ready, m_ready);
    chk("in_ready4", in_ready4, m_ready);
    chk("sbit_cnt", sbit_cnt, sat(sb_tot, 65535));
    chk("dbit_cnt", dbit_cnt, sat(db_tot, 65535));
    chk("sbit_cnt4", sbit_cnt4, sat(sb_tot, 15));
    chk("dbit_cnt4", dbit_cnt4, sat(db_tot, 15));
    chk("err_addr", err_addr, m_addr);
    chk("err_addr_vld", err_addr_vld, m_st != 0);
    chk("err_irq", err_irq, (m_st == 2) || (sat(sb_tot, 65535) >= 16));
    chk("err_irq4", err_irq4, (m_st == 2) || (sat(sb_tot, 15) >= 16));
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid    = 1'b0;
    in_sbit_err = 1'b0;
    in_dbit_err = 1'b0;
    err_clr     = 1'b0;
  endtask

  task automatic drive(input logic [55:0] d, input bit s, input bit db, input logic [7:0] a);
    in_valid    = 1'b1;
    in_data     = d;
    in_sbit_err = s;
    in_dbit_err = db;
    in_addr     = a;
  endtask

  logic [63:0] rnd;

  initial begin
    idle();
    out_ready = 1'b0;
    in_data   = '0;
    in_addr   = '0;
    step();
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_irq", err_irq, 0);
    rst_n = 1'b1;
    step();
    chk("ready_after_rst", in_ready, 1);

    // Back-to-back clean beats
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(56'h100 + 56'(i), 1'b0, 1'b0, 8'h01);
      step();
      chk("b2b_valid", out_valid, 1);
      chk("b2b_data", out_data, 56'h100 + 56'(i));
      chk("b2b_ready", in_ready, 1);
    end
    idle();
    step();
    chk("b2b_drained", out_valid, 0);
    chk("b2b_sbit0", sbit_cnt, 0);
    chk("b2b_dbit0", dbit_cnt, 0);

    // Backpressure: third beat waits, nothing lost
    out_ready = 1'b0;
    drive(56'hA0, 1'b0, 1'b0, 8'h02);
    step();
    drive(56'hB0, 1'b0, 1'b0, 8'h02);
    step();
    chk("bp_full_ready", in_ready, 0);
    chk("bp_head", out_data, 56'hA0);
    drive(56'hC0, 1'b0, 1'b0, 8'h02);
    step();
    chk("bp_still_full", in_ready, 0);
    out_ready = 1'b1;
    step();
    chk("bp_ready_back", in_ready, 1);
    chk("bp_second", out_data, 56'hB0);
    step();
    chk("bp_third", out_data, 56'hC0);
    idle();
    step();
    chk("bp_empty", out_valid, 0);

    // Single then double error capture
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    drive(56'h11, 1'b1, 1'b0, 8'h12);
    step();
    chk("sb_poison", out_poison, 0);
    chk("sb_addr", err_addr, 8'h12);
    drive(56'h22, 1'b0, 1'b1, 8'h34);
    step();
    chk("db_poison", out_poison, 1);
    chk("db_sbit", sbit_cnt, 1);
    chk("db_dbit", dbit_cnt, 1);
    chk("db_addr", err_addr, 8'h34);
    chk("db_vld", err_addr_vld, 1);
    chk("db_irq", err_irq, 1);
    idle();
    step();

    // Threshold and saturation
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("thr_irq_clr", err_irq, 0);
    for (int i = 1; i <= 20; i++) begin
      drive(56'(i), 1'b1, 1'b0, 8'(i));
      step();
      if (i == 15) chk("thr_irq_15", err_irq, 0);
      if (i == 16) chk("thr_irq_16", err_irq, 1);
    end
    idle();
    step();
    chk("thr_sbit20", sbit_cnt, 20);
    chk("thr_sat4", sbit_cnt4, 15);
    chk("thr_irq4", err_irq4, 0);
    chk("thr_addr_first", err_addr, 8'h01);

    // Clear coincident with an accepted beat
    drive(56'h77, 1'b0, 1'b1, 8'h77);
    step();
    drive(56'h55, 1'b1, 1'b0, 8'h55);
    err_clr = 1'b1;
    step();
    idle();
    chk("clr_sbit", sbit_cnt, 1);
    chk("clr_dbit", dbit_cnt, 0);
    chk("clr_addr", err_addr, 8'h55);
    chk("clr_vld", err_addr_vld, 1);
    chk("clr_irq", err_irq, 0);
    step();

    // Reset with two entries held
    out_ready = 1'b0;
    drive(56'hE0, 1'b0, 1'b1, 8'h0E);
    step();
    drive(56'hF0, 1'b1, 1'b0, 8'h0F);
    step();
    idle();
    chk("mid_full", in_ready, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_dbit", dbit_cnt, 0);
    chk("mid_rst_vld", err_addr_vld, 0);
    chk("mid_rst_irq", err_irq, 0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mid_no_stale", out_valid, 0);
    end
    chk("mid_ready_back", in_ready, 1);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rnd = {$urandom, $urandom};
      in_valid    = ($urandom % 4) != 0;
      in_data     = rnd[55:0];
      in_sbit_err = ($urandom % 3) == 0;
      in_dbit_err = ($urandom % 10) == 0;
      in_addr     = 8'($urandom);
      out_ready   = ($urandom % 3) != 0;
      err_clr     = ($urandom % 60) == 0;
      if (c == 1500) begin #1 rst_n = 1'b0; end
      if (c == 1502) begin #1 rst_n = 1'b1; end
      step();
    end
    idle();
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ecc_56_rd_stage.md
ECC_56_RD_STAGE -- requirements
Module: ecc_56_rd_stage

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 56, meaning the width of the corrected data word from the ECC decoder.
REQ-002 The block SHALL have parameter ADDR_W, default 8, meaning the width of the read address tag carried with each word.
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning the width of each error counter.
REQ-004 The block SHALL have parameter SBIT_THR, default 16, meaning the single-bit count at which the interrupt fires.
REQ-005 The block SHALL have port clk  in  1  meaning the single clock; it is the only clock.
REQ-006 The block SHALL have port rst_n  in  1  meaning the reset, asynchronous and active-low.
REQ-007 The block SHALL have ports in_valid in 1, in_ready out 1, in_data in DATA_WIDTH, in_sbit_err in 1, in_dbit_err in 1, in_addr in ADDR_W, meaning the upstream beat carrying decoder data_out, sbit_err, dbit_err and address tag.
REQ-008 The block SHALL have ports out_valid out 1, out_ready in 1, out_data out DATA_WIDTH, out_poison out 1, meaning the downstream beat, with poison marking an uncorrectable word.
REQ-009 The block SHALL have ports err_clr in 1, sbit_cnt out CNT_W, dbit_cnt out CNT_W, err_addr out ADDR_W, err_addr_vld out 1, err_irq out 1, meaning the error status interface.

Function
REQ-010 An input beat SHALL be accepted when in_valid && in_ready; an output beat SHALL transfer when out_valid && out_ready.
REQ-011 The data path SHALL be a 2-entry FIFO (skid buffer), with in_ready driven from a register and equal to "fewer than 2 entries held".
REQ-012 Latency SHALL be 1 cycle: a beat accepted into an empty buffer appears on out_valid the next cycle.
REQ-013 Beat order SHALL be preserved; out_poison = accepted in_dbit_err of that beat; out_data = in_data unmodified.
REQ-014 When full with out_ready high, one beat SHALL drain and in_ready SHALL return high the next cycle; simultaneous accept and drain SHALL keep occupancy unchanged.
REQ-015 sbit_cnt SHALL increment by 1 per accepted beat with in_sbit_err=1 and in_dbit_err=0; dbit_cnt SHALL increment per accepted beat with in_dbit_err=1 (dbit wins if both set).
REQ-016 Both counters SHALL saturate at all-ones and never wrap.
REQ-017 The capture FSM SHALL have states IDLE, SB_HELD and DB_HELD: IDLE->SB_HELD on an accepted sbit beat; IDLE or SB_HELD->DB_HELD on an accepted dbit beat; DB_HELD holds until err_clr.
REQ-018 err_addr SHALL load in_addr on each transition into SB_HELD or DB_HELD only; err_addr_vld = (state != IDLE).
REQ-019 err_irq SHALL be registered and equal (state == DB_HELD) || (sbit_cnt >= SBIT_THR).
REQ-020 err_clr SHALL zero both counters, err_addr and the FSM (state IDLE) the next cycle; a beat accepted in the same cycle SHALL be applied after the clear (counter = 1, FSM captures it).
REQ-021 err_clr SHALL not affect the data path.

Reset
REQ-022 On rst_n low, all of the following SHALL take these values asynchronously: out_valid=0, in_ready=0, FIFO empty, counters=0, err_addr=0, err_addr_vld=0, err_irq=0, FSM=IDLE.
REQ-023 in_ready SHALL rise on the first clk edge after rst_n deasserts; beats in flight at reset SHALL be discarded.

Structure
REQ-024 The FSM state enum and the default widths (56, 7 parity, ADDR_W, CNT_W) SHALL live in a shared ecc_pkg package.
REQ-025 The 2-entry buffer SHALL be sub-module ecc_skid_buf, parameterised by payload width (DATA_WIDTH+1); counters and FSM SHALL remain in the top.

Verification
REQ-026 Back-to-back clean beats, out_ready=1: 10 beats accepted in 10 cycles, out_data equal and in order, 1-cycle latency, counters stay 0.
REQ-027 out_ready=0 with 3 offered beats: 2 accepted, in_ready=0 after the second; with out_ready=1, in_ready=1 one cycle later and no loss.
REQ-028 sbit beat at addr 0x12, then dbit beat at 0x34: sbit_cnt=1, dbit_cnt=1, err_addr=0x34, FSM DB_HELD, err_irq=1, out_poison=1 on the second beat only.
REQ-029 17 sbit beats with SBIT_THR=16: err_irq rises the cycle after the 16th sbit count; with CNT_W=4, 20 sbit beats give sbit_cnt=15.
REQ-030 err_clr coincident with an accepted sbit beat at 0x55: next cycle sbit_cnt=1, dbit_cnt=0, err_addr=0x55, state SB_HELD, err_irq=0.
REQ-031 rst_n pulsed low mid-stream with 2 entries held: all outputs go to reset values immediately, and the held beats never appear on the output.
